// File: rtl/msrh_lsu_pkg.sv
// msrh_lsu_pkg: shared LSU types for the snoop requester.
// FSM state, upstream response status and L1D lookup status.
package msrh_lsu_pkg;

  typedef enum logic [2:0] {
    SNOOP_IDLE,
    SNOOP_ISSUE,
    SNOOP_WAIT_S1,
    SNOOP_BACKOFF,
    SNOOP_RESP
  } snoop_fsm_t;

  typedef enum logic [1:0] {
    SNOOP_RESP_OK    = 2'd0,
    SNOOP_RESP_ABORT = 2'd1
  } snoop_resp_status_t;

  typedef enum logic [1:0] {
    LSU_STATUS_NONE     = 2'd0,
    LSU_STATUS_HIT      = 2'd1,
    LSU_STATUS_MISS     = 2'd2,
    LSU_STATUS_CONFLICT = 2'd3
  } lsu_status_t;

endpackage

// File: rtl/msrh_snoop_byte_merge.sv
// msrh_snoop_byte_merge: per-byte merge of L1D line and STQ bytes.
// STQ bytes win; L1D bytes only contribute when l1d_en (HIT).
module msrh_snoop_byte_merge #(
  parameter int DATA_W = 256,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              l1d_en,
  input  logic [DATA_W-1:0] l1d_data,
  input  logic [BE_W-1:0]   l1d_be,
  input  logic [DATA_W-1:0] stq_data,
  input  logic [BE_W-1:0]   stq_be,
  output logic [DATA_W-1:0] data,
  output logic [BE_W-1:0]   be
);

  for (genvar i = 0; i < BE_W; i++) begin : g_byte
    assign data[i*8 +: 8] =
      stq_be[i] ? stq_data[i*8 +: 8] :
      l1d_en    ? l1d_data[i*8 +: 8] :
                  8'h00;
  end

  assign be = stq_be | (l1d_en ? l1d_be : '0);

endmodule

// File: rtl/msrh_snoop_requester.sv
// msrh_snoop_requester: probes L1D and STQ for one snoop at a time.
// Optional perf counters: define MSRH_SNOOP_REQUESTER_PERF_EN.
module msrh_snoop_requester
  import msrh_lsu_pkg::*;
#(
  parameter int PADDR_W       = 56,
  parameter int DCACHE_DATA_W = 256,
  parameter int TAG_W         = 4,
  parameter int RETRY_WAIT    = 3,
  parameter int MAX_RETRY     = 15
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_snoop_req_valid,
  output logic                       o_snoop_req_ready,
  input  logic [PADDR_W-1:0]         i_snoop_req_paddr,
  input  logic [TAG_W-1:0]           i_snoop_req_tag,
  output logic                       o_l1d_req_s0_valid,
  output logic [PADDR_W-1:0]         o_l1d_req_s0_paddr,
  input  logic                       i_l1d_resp_s1_valid,
  input  logic [1:0]                 i_l1d_resp_s1_status,
  input  logic [DCACHE_DATA_W-1:0]   i_l1d_resp_s1_data,
  input  logic [DCACHE_DATA_W/8-1:0] i_l1d_resp_s1_be,
  output logic                       o_stq_req_s0_valid,
  output logic [PADDR_W-1:0]         o_stq_req_s0_paddr,
  input  logic                       i_stq_resp_s1_valid,
  input  logic [DCACHE_DATA_W-1:0]   i_stq_resp_s1_data,
  input  logic [DCACHE_DATA_W/8-1:0] i_stq_resp_s1_be,
  output logic                       o_snoop_resp_valid,
  input  logic                       i_snoop_resp_ready,
  output logic [1:0]                 o_snoop_resp_status,
  output logic [TAG_W-1:0]           o_snoop_resp_tag,
  output logic [DCACHE_DATA_W-1:0]   o_snoop_resp_data,
  output logic [DCACHE_DATA_W/8-1:0] o_snoop_resp_be
`ifdef MSRH_SNOOP_REQUESTER_PERF_EN
  ,
  output logic [31:0]                o_perf_snoop_cnt,
  output logic [31:0]                o_perf_hit_cnt,
  output logic [31:0]                o_perf_conflict_cnt
`endif
);

  localparam int BE_W   = DCACHE_DATA_W / 8;
  localparam int RCNT_W =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WCNT_W =
    (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
  localparam logic [RCNT_W-1:0] RCNT_MAX =
    RCNT_W'(MAX_RETRY);
  localparam logic [WCNT_W-1:0] WCNT_INIT =
    WCNT_W'(RETRY_WAIT - 1);

  snoop_fsm_t          state;
  logic [PADDR_W-1:0]  paddr_q;
  logic [RCNT_W-1:0]   retry_q;
  logic [WCNT_W-1:0]   wait_q;
  logic                s0_valid_q;

  logic                s1_both;
  lsu_status_t         s1_st;
  logic                s1_hit;
  logic                s1_conflict;
  logic                retry_done;
  logic [DCACHE_DATA_W-1:0] m_data;
  logic [BE_W-1:0]     m_be;

  assign s1_both     = i_l1d_resp_s1_valid
                     & i_stq_resp_s1_valid;
  assign s1_st       = s1_both
                     ? lsu_status_t'(i_l1d_resp_s1_status)
                     : LSU_STATUS_CONFLICT;
  assign s1_hit      = (s1_st == LSU_STATUS_HIT);
  assign s1_conflict = (s1_st == LSU_STATUS_CONFLICT);
  assign retry_done  = (retry_q == RCNT_MAX);

  msrh_snoop_byte_merge #(
    .DATA_W (DCACHE_DATA_W)
  ) u_merge (
    .l1d_en   (s1_hit),
    .l1d_data (i_l1d_resp_s1_data),
    .l1d_be   (i_l1d_resp_s1_be),
    .stq_data (i_stq_resp_s1_data),
    .stq_be   (i_stq_resp_s1_be),
    .data     (m_data),
    .be       (m_be)
  );

  assign o_l1d_req_s0_valid = s0_valid_q;
  assign o_stq_req_s0_valid = s0_valid_q;
  assign o_l1d_req_s0_paddr = paddr_q;
  assign o_stq_req_s0_paddr = paddr_q;

  // Snoop FSM with registered handshake, probe and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state               <= SNOOP_IDLE;
      o_snoop_req_ready   <= 1'b1;
      s0_valid_q          <= 1'b0;
      paddr_q             <= '0;
      retry_q             <= '0;
      wait_q              <= '0;
      o_snoop_resp_valid  <= 1'b0;
      o_snoop_resp_status <= SNOOP_RESP_OK;
      o_snoop_resp_tag    <= '0;
      o_snoop_resp_data   <= '0;
      o_snoop_resp_be     <= '0;
    end else begin
      unique case (state)
        SNOOP_IDLE: begin
          if (i_snoop_req_valid && o_snoop_req_ready) begin
            paddr_q           <= i_snoop_req_paddr;
            o_snoop_resp_tag  <= i_snoop_req_tag;
            retry_q           <= '0;
            o_snoop_req_ready <= 1'b0;
            s0_valid_q        <= 1'b1;
            state             <= SNOOP_ISSUE;
          end
        end
        SNOOP_ISSUE: begin
          s0_valid_q <= 1'b0;
          state      <= SNOOP_WAIT_S1;
        end
        SNOOP_WAIT_S1: begin
          if (!s1_conflict) begin
            o_snoop_resp_data   <= m_data;
            o_snoop_resp_be     <= m_be;
            o_snoop_resp_status <= SNOOP_RESP_OK;
            o_snoop_resp_valid  <= 1'b1;
            state               <= SNOOP_RESP;
          end else if (retry_done) begin
            o_snoop_resp_data   <= '0;
            o_snoop_resp_be     <= '0;
            o_snoop_resp_status <= SNOOP_RESP_ABORT;
            o_snoop_resp_valid  <= 1'b1;
            state               <= SNOOP_RESP;
          end else begin
            retry_q <= retry_q + RCNT_W'(1);
            wait_q  <= WCNT_INIT;
            state   <= SNOOP_BACKOFF;
          end
        end
        SNOOP_BACKOFF: begin
          if (wait_q == '0) begin
            s0_valid_q <= 1'b1;
            state      <= SNOOP_ISSUE;
          end else begin
            wait_q <= wait_q - WCNT_W'(1);
          end
        end
        SNOOP_RESP: begin
          if (i_snoop_resp_ready) begin
            o_snoop_resp_valid <= 1'b0;
            o_snoop_req_ready  <= 1'b1;
            state              <= SNOOP_IDLE;
          end
        end
        default: state <= SNOOP_IDLE;
      endcase
    end
  end

`ifdef MSRH_SNOOP_REQUESTER_PERF_EN
  logic in_s1;
  logic ev_resp;
  logic ev_hit;
  logic ev_cf;

  assign in_s1   = (state == SNOOP_WAIT_S1);
  assign ev_resp = in_s1 & (~s1_conflict | retry_done);
  assign ev_hit  = in_s1 & s1_hit;
  assign ev_cf   = in_s1 & s1_conflict;

  // Saturating event counters sampled on the s1 outcome.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_perf_snoop_cnt    <= '0;
      o_perf_hit_cnt      <= '0;
      o_perf_conflict_cnt <= '0;
    end else begin
      if (ev_resp && (o_perf_snoop_cnt != '1))
        o_perf_snoop_cnt <= o_perf_snoop_cnt + 32'd1;
      if (ev_hit && (o_perf_hit_cnt != '1))
        o_perf_hit_cnt <= o_perf_hit_cnt + 32'd1;
      if (ev_cf && (o_perf_conflict_cnt != '1))
        o_perf_conflict_cnt <= o_perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
